// File: rtl/sat_pkg.sv
// Shared definitions for the SAT solver front end and the solver core:
// command opcodes, response codes, literal layout and sequencer states.
package sat_pkg;

  // Solver command opcodes (also the first byte of a host frame).
  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_RESET  = 8'h01;
  localparam logic [7:0] CMD_CLAUSE = 8'h02;
  localparam logic [7:0] CMD_SOLVE  = 8'h03;
  localparam logic [7:0] CMD_READ   = 8'h04;

  // Response bytes returned to the host after SOLVE.
  localparam logic [7:0] RSP_SAT     = 8'h01;
  localparam logic [7:0] RSP_UNSAT   = 8'h02;
  localparam logic [7:0] RSP_TIMEOUT = 8'hFF;

  // Literal byte: bit7 = negated, bits6:0 = variable index, 0x00 = empty slot.
  localparam int LIT_NEG_BIT = 7;
  localparam int LIT_VAR_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPERAND,
    ST_ISSUE,
    ST_WAIT_SOLVE,
    ST_WAIT_READ,
    ST_EMIT
  } seq_state_t;

endpackage

// File: rtl/sat_frame_decoder.sv
// Classifies a frame opcode byte: whether it is a known command and how
// many operand bytes follow it.
module sat_frame_decoder
  import sat_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       legal,
  output logic [1:0] n_operands
);

  // Opcode lookup; anything outside the command set is illegal.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    legal      = 1'b1;
    n_operands = 2'd0;
    case (opcode)
      CMD_NOP, CMD_RESET, CMD_SOLVE: n_operands = 2'd0;
      CMD_CLAUSE:                    n_operands = 2'd3;
      CMD_READ:                      n_operands = 2'd1;
      default:                       legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/sat_cmd_sequencer.sv
// Front end for the SAT solver core: collects framed host commands, issues
// one-cycle command pulses with operands, waits for solve results or read
// data and returns a response byte to the host.
module sat_cmd_sequencer
  import sat_pkg::*;
#(
  parameter  int MAX_CLAUSES   = 256,
  parameter  int SOLVE_TIMEOUT = 1048576,
  parameter  int READ_LAT      = 1,
  localparam int CW            = $clog2(MAX_CLAUSES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    cmd,
  output logic [7:0]    bus_a,
  output logic [7:0]    bus_b,
  output logic [7:0]    bus_c,
  input  logic          sat,
  input  logic          unsat,
  input  logic [7:0]    exbus,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] clause_count
);

  // One timer serves both the solve timeout and the read latency.
  localparam int TW = $clog2(SOLVE_TIMEOUT + READ_LAT + 2);

  seq_state_t    state, state_nxt;
  logic [7:0]    opcode_q, opnd0, opnd1, rsp, launch_op;
  logic [1:0]    opnd_left, dec_nops;
  logic [TW-1:0] timer;
  logic          dec_legal, accept, launch, cap_full, timed_out, read_due;

  sat_frame_decoder u_dec (
    .opcode     (in_data),
    .legal      (dec_legal),
    .n_operands (dec_nops)
  );

  assign in_ready  = (state == ST_IDLE) || (state == ST_OPERAND);
  assign accept    = in_valid && in_ready;
  assign out_data  = rsp;
  assign launch_op = (state == ST_IDLE) ? in_data : opcode_q;
  assign cap_full  = (clause_count == CW'(MAX_CLAUSES));
  assign timed_out = (SOLVE_TIMEOUT != 0) && (timer == TW'(SOLVE_TIMEOUT - 1));
  assign read_due  = (timer == TW'(READ_LAT - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, launch strobe (final frame byte taken) and status outputs.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_EMIT);
    case (state)
      ST_IDLE:
        if (accept && dec_legal && (in_data != CMD_NOP)) begin
          if (dec_nops == 2'd0) begin
            launch    = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_OPERAND;
          end
        end
      ST_OPERAND:
        if (accept && (opnd_left == 2'd1)) begin
          launch    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      ST_ISSUE:
        case (opcode_q)
          CMD_SOLVE: state_nxt = ST_WAIT_SOLVE;
          CMD_READ:  state_nxt = ST_WAIT_READ;
          default:   state_nxt = ST_IDLE;
        endcase
      ST_WAIT_SOLVE:
        if (sat || unsat || timed_out) state_nxt = ST_EMIT;
      ST_WAIT_READ:
        if (read_due) state_nxt = ST_EMIT;
      ST_EMIT:
        if (out_ready) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Frame capture, command issue, counters, error flag and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_q     <= CMD_NOP;
      opnd_left    <= 2'd0;
      opnd0        <= 8'h00;
      opnd1        <= 8'h00;
      cmd          <= CMD_NOP;
      bus_a        <= 8'h00;
      bus_b        <= 8'h00;
      bus_c        <= 8'h00;
      clause_count <= '0;
      err          <= 1'b0;
      timer        <= '0;
      rsp          <= 8'h00;
    end else begin
      // The command pulse lasts only the cycle after launch.
      cmd <= CMD_NOP;

      if (state == ST_IDLE && accept) begin
        opcode_q  <= in_data;
        opnd_left <= dec_nops;
        if (!dec_legal) err <= 1'b1;
      end

      if (state == ST_OPERAND && accept) begin
        opnd_left <= opnd_left - 2'd1;
        if (opnd_left == 2'd3) opnd0 <= in_data;
        if (opnd_left == 2'd2) opnd1 <= in_data;
      end

      // Counters and flags change together with the pulse so the solver and
      // the host see a consistent view during the ISSUE cycle.
      if (launch) begin
        case (launch_op)
          CMD_RESET: begin
            cmd          <= CMD_RESET;
            clause_count <= '0;
            err          <= 1'b0;
          end
          CMD_CLAUSE: begin
            if (cap_full) begin
              err <= 1'b1;
            end else begin
              cmd          <= CMD_CLAUSE;
              bus_a        <= opnd0;
              bus_b        <= opnd1;
              bus_c        <= in_data;
              clause_count <= clause_count + 1'b1;
            end
          end
          CMD_SOLVE: cmd <= CMD_SOLVE;
          CMD_READ: begin
            cmd   <= CMD_READ;
            bus_a <= in_data;
          end
          default: ;
        endcase
      end

      if (state == ST_ISSUE) timer <= '0;
      else if (state == ST_WAIT_SOLVE || state == ST_WAIT_READ) timer <= timer + 1'b1;

      if (state == ST_WAIT_SOLVE) begin
        if (sat) begin
          rsp <= RSP_SAT;
        end else if (unsat) begin
          rsp <= RSP_UNSAT;
        end else if (timed_out) begin
          rsp <= RSP_TIMEOUT;
          err <= 1'b1;
        end
      end

      if (state == ST_WAIT_READ && read_due) rsp <= exbus;
    end
  end

endmodule

// File: doc/sat_cmd_sequencer.md
Name: sat_cmd_sequencer

Overview:
- Upstream front end for the SAT solver core.
- Accepts a framed byte stream (valid/ready) of solver commands and operands, and drives the solver's cmd/bus_a/bus_b/bus_c with one-cycle command pulses.
- Waits for sat/unsat after SOLVE and captures exbus after READ.
- Returns status and result bytes on an output byte stream.

Parameters:
- MAX_CLAUSES, 256: clause capacity of the solver core; further CLAUSE frames are rejected.
- SOLVE_TIMEOUT, 1048576: cycles to wait for sat/unsat after SOLVE; 0 = wait forever.
- READ_LAT, 1: cycles from READ pulse to valid exbus (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  8  host byte stream data
- in_valid  in  1  host byte valid
- in_ready  out  1  sequencer can accept byte
- out_data  out  8  response byte
- out_valid  out  1  response valid
- out_ready  in  1  host accepts response
- cmd  out  8  solver command (NOP=0x00 when idle)
- bus_a  out  8  solver operand A
- bus_b  out  8  solver operand B
- bus_c  out  8  solver operand C
- sat  in  1  solver reports satisfiable
- unsat  in  1  solver reports unsatisfiable
- exbus  in  8  solver extraction bus
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag
- clause_count  out  $clog2(MAX_CLAUSES+1)  clauses issued since last RESET

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, cmd=bus_a=bus_b=bus_c=0, busy=0, err=0, clause_count=0. Reset mid-frame discards partial operands and any pending response.
- Byte transfer: a byte is accepted when in_valid & in_ready. in_ready=1 only in IDLE and OPERAND.
- Frame = opcode byte, then operands:
  - RESET 0x01: 0 operands.
  - CLAUSE 0x02: 3 operands, literals -> bus_a, bus_b, bus_c.
  - SOLVE 0x03: 0 operands.
  - READ 0x04: 1 operand, variable index -> bus_a.
  - NOP 0x00: consumed, no action.
- Literal encoding (passed through unchanged): bit7 = negated, bits6:0 = variable; 0x00 = empty slot.
- Unknown opcode: byte dropped, err set, stay IDLE.
- States and transitions:
  - IDLE: opcode accepted -> OPERAND if operands>0, else ISSUE.
  - OPERAND: operand counter; last operand accepted -> ISSUE.
  - ISSUE: cmd = opcode and buses valid for exactly one cycle, then cmd returns to 0x00. Buses hold last values. Next state by opcode: RESET/CLAUSE -> IDLE, SOLVE -> WAIT_SOLVE, READ -> WAIT_READ.
  - WAIT_SOLVE: sat/unsat sampled from the cycle after ISSUE onward.
    - sat -> response 0x01; unsat -> response 0x02; both high -> sat wins (0x01); go to EMIT.
    - Timeout counter reaches SOLVE_TIMEOUT -> response 0xFF, err set, go to EMIT.
  - WAIT_READ: count READ_LAT cycles after ISSUE, register exbus into response, go to EMIT.
  - EMIT: out_valid=1, out_data stable until out_ready; the handshake cycle returns to IDLE. Back-to-back frames are therefore never overlapped with pending output.
- RESET issue: clause_count=0 and err=0 in the same cycle the pulse is driven.
- CLAUSE issue: clause_count increments.
- CLAUSE with clause_count==MAX_CLAUSES: no pulse issued, err set, count saturates, return to IDLE.
- Latency: last byte accepted at cycle t -> cmd pulse at t+1. READ response valid at t+2+READ_LAT at the earliest.

Decomposition:
- Shared package sat_pkg: opcode constants (CMD_NOP/RESET/CLAUSE/SOLVE/READ), response codes (RSP_SAT=0x01, RSP_UNSAT=0x02, RSP_TIMEOUT=0xFF), literal field widths, state enum.
- The solver core uses the same opcode constants.
- One natural sub-module: sat_frame_decoder (opcode -> operand count/valid/legal). Everything else stays in the sequencer.

Test Plan:
- Reset then stream 02 81 03 00 -> one cycle with cmd=0x02, bus_a=0x81, bus_b=0x03, bus_c=0x00; clause_count=1; cmd=0x00 the following cycle.
- Stream 03, unsat pulsed 5 cycles after ISSUE, out_ready held low 3 cycles -> out_data=0x02 held stable with out_valid=1 until the handshake; in_ready=0 throughout.
- Stream 04 07, exbus=0xA5 at READ_LAT cycles -> cmd=0x04 with bus_a=0x07, then response 0xA5.
- SOLVE_TIMEOUT=16, SOLVE with no sat/unsat -> response 0xFF, err=1. Then RESET frame -> err=0, clause_count=0.
- MAX_CLAUSES=2, three CLAUSE frames -> two pulses, third suppressed, err=1, clause_count=2. Stream 0x7E -> dropped, err stays 1.
- rst_n low after the second operand of a CLAUSE -> no pulse, IDLE, all outputs at reset values. A subsequent full frame is decoded correctly.
